// File: rtl/cgra_read_arbiter.sv
// Round-robin arbiter folding NUM_REQ read requesters onto one AXI-Lite read port.
// Grant order is remembered in an in-order FIFO so R beats are routed back to their requester.
module cgra_read_arbiter #(
   parameter int NUM_REQ     = 5,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int OUTST_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [DATA_WIDTH-1:0]         rsp_data_o,
   output logic                          rsp_err_o,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   input  logic [NUM_REQ-1:0]            rsp_ready_i,
   output logic [ADDR_WIDTH-1:0]         ar_addr_o,
   output logic                          ar_valid_o,
   input  logic                          ar_ready_i,
   input  logic [DATA_WIDTH-1:0]         r_data_i,
   input  logic [1:0]                    r_resp_i,
   input  logic                          r_valid_i,
   output logic                          r_ready_o,
   output logic                          outst_full_o,
   output logic                          unexpected_rsp_o
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = $clog2(OUTST_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic                  ar_valid_q, ar_valid_d;
   logic                  unexp_q, unexp_d;
   logic [IDX_W-1:0]      fifo_q [OUTST_DEPTH];

   logic                  fifo_empty, fifo_full, grant, push, pop;
   logic [IDX_W-1:0]      win_idx, head_idx;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(OUTST_DEPTH));
   // Full is judged on the registered count, so a pop this cycle never frees a slot for a push.
   assign grant      = !rst_i && (|req_valid_i) && !fifo_full && (!ar_valid_q || ar_ready_i);
   assign push       = grant;
   assign head_idx   = fifo_q[rd_ptr_q];
   assign r_ready_o  = !fifo_empty && rsp_ready_i[head_idx];
   assign pop        = r_valid_i && r_ready_o;

   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      logic             found;
      win_idx = '0;
      found   = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
         cand = sum[IDX_W-1:0];
         if (!found && req_valid_i[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (grant) req_ready_o[win_idx] = 1'b1;
      rsp_valid_o = '0;
      if (r_valid_i && !fifo_empty) rsp_valid_o[head_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      ar_addr_d  = ar_addr_q;
      ar_valid_d = ar_valid_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      unexp_d    = unexp_q || (r_valid_i && fifo_empty);
      if (grant) begin
         rr_ptr_d   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
         ar_addr_d  = req_addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         ar_valid_d = 1'b1;
      end else if (ar_ready_i) begin
         ar_valid_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         ar_addr_q  <= '0;
         ar_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         unexp_q    <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         ar_addr_q  <= ar_addr_d;
         ar_valid_q <= ar_valid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         unexp_q    <= unexp_d;
      end
   end

   // Entry storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= win_idx;
   end

   assign ar_addr_o        = ar_addr_q;
   assign ar_valid_o       = ar_valid_q;
   assign rsp_data_o       = r_data_i;
   assign rsp_err_o        = (r_resp_i != 2'b00);
   assign outst_full_o     = fifo_full;
   assign unexpected_rsp_o = unexp_q;
endmodule

// File: tb/tb_cgra_read_arbiter.sv
// Bench for cgra_read_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cgra_read_arbiter;
   localparam int N     = 5;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [N*AW-1:0] req_addr_i;
   logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
   logic [DW-1:0]   rsp_data_o, r_data_i;
   logic            rsp_err_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
   logic [AW-1:0]   ar_addr_o;
   logic [1:0]      r_resp_i;
   logic            outst_full_o, unexpected_rsp_o;

   cgra_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTST_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_addr_i(req_addr_i), .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .ar_addr_o(ar_addr_o),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .outst_full_o(outst_full_o),
      .unexpected_rsp_o(unexpected_rsp_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: outstanding requester indices in issue order, RR pointer, AR slot.
   logic [2:0]    exp_q[$];
   int            m_p;
   logic          m_ar_valid;
   logic [AW-1:0] m_ar_addr;
   logic          m_unexp;

   task automatic model_reset();
      exp_q.delete();
      m_p        = 0;
      m_ar_valid = 1'b0;
      m_ar_addr  = '0;
      m_unexp    = 1'b0;
   endtask

   // One clock: inputs are already driven; check at negedge, advance model at posedge.
   task automatic step();
      logic         g, empty, rr;
      int           win, k, head;
      logic [N-1:0] e_req, e_rv;
      @(negedge clk_i);
      empty = (exp_q.size() == 0);
      g     = 1'b0;
      win   = 0;
      if (req_valid_i != '0 && exp_q.size() < DEPTH && (!m_ar_valid || ar_ready_i)) begin
         for (int i = 0; i < N; i++) begin
            k = (m_p + i) % N;
            if (!g && req_valid_i[k]) begin
               g   = 1'b1;
               win = k;
            end
         end
      end
      e_req = '0;
      if (g) e_req[win] = 1'b1;
      head = empty ? 0 : int'(exp_q[0]);
      e_rv = '0;
      if (r_valid_i && !empty) e_rv[head] = 1'b1;
      rr = !empty && rsp_ready_i[head];
      check("req_ready", req_ready_o, e_req);
      check("ar_valid", ar_valid_o, m_ar_valid);
      check("ar_addr", ar_addr_o, m_ar_addr);
      check("rsp_valid", rsp_valid_o, e_rv);
      check("r_ready", r_ready_o, rr);
      check("rsp_data", rsp_data_o, r_data_i);
      check("rsp_err", rsp_err_o, r_resp_i != 2'b00);
      check("outst_full", outst_full_o, exp_q.size() == DEPTH);
      check("unexpected", unexpected_rsp_o, m_unexp);
      @(posedge clk_i);
      if (r_valid_i && rr) void'(exp_q.pop_front());
      if (r_valid_i && empty) m_unexp = 1'b1;
      if (g) begin
         exp_q.push_back(3'(win));
         m_ar_addr  = req_addr_i[win*AW +: AW];
         m_ar_valid = 1'b1;
         m_p        = (win + 1) % N;
      end else if (ar_ready_i) begin
         m_ar_valid = 1'b0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      req_valid_i = '0;
      ar_ready_i  = 1'b0;
      r_valid_i   = 1'b0;
      r_resp_i    = 2'b00;
      r_data_i    = '0;
      rsp_ready_i = '0;
      for (int i = 0; i < N; i++) req_addr_i[i*AW +: AW] = $urandom;
   endtask

   // Holds reset with live-looking inputs so output gating is exercised, then releases.
   task automatic do_reset(input int cycles);
      rst_i       = 1'b1;
      req_valid_i = '1;
      ar_ready_i  = 1'b1;
      r_valid_i   = 1'b1;
      rsp_ready_i = '1;
      model_reset();
      repeat (cycles) begin
         @(negedge clk_i);
         check("rst_req_ready", req_ready_o, 0);
         check("rst_rsp_valid", rsp_valid_o, 0);
         check("rst_r_ready", r_ready_o, 0);
         check("rst_ar_valid", ar_valid_o, 0);
         check("rst_ar_addr", ar_addr_o, 0);
         check("rst_full", outst_full_o, 0);
         check("rst_unexpected", unexpected_rsp_o, 0);
         @(posedge clk_i);
         #1;
      end
      idle_inputs();
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      do_reset(3);

      // Fairness: everyone requesting, AR always ready, responses returned promptly.
      do_reset(1);
      req_valid_i = '1;
      ar_ready_i  = 1'b1;
      rsp_ready_i = '1;
      for (int c = 0; c < 10; c++) begin
         r_valid_i = (exp_q.size() != 0);
         r_data_i  = $urandom;
         #1 check("fair_grant", req_ready_o, 64'(1) << (c % 5));
         step();
      end

      // Backpressure on AR with a single request from requester 2.
      do_reset(1);
      req_addr_i[2*AW +: AW] = 32'h8000_0010;
      req_valid_i = 5'b00100;
      #1 check("bp_grant", req_ready_o, 5'b00100);
      step();
      for (int c = 0; c < 4; c++) begin
         req_valid_i = 5'b00001;
         ar_ready_i  = (c == 3);
         #1;
         check("bp_ar_valid", ar_valid_o, 1);
         check("bp_ar_addr", ar_addr_o, 32'h8000_0010);
         check("bp_req_ready", req_ready_o, (c == 3) ? 5'b00001 : 5'b00000);
         step();
      end
      idle_inputs();
      step();

      // Full: four grants with no responses, then a pop does not allow a same-cycle push.
      do_reset(1);
      req_valid_i = '1;
      ar_ready_i  = 1'b1;
      rsp_ready_i = '1;
      repeat (4) step();
      check("full_flag", outst_full_o, 1);
      #1 check("full_no_grant", req_ready_o, 0);
      step();
      r_valid_i = 1'b1;
      #1;
      check("full_pop_no_grant", req_ready_o, 0);
      check("full_pop_ready", r_ready_o, 1);
      step();
      r_valid_i = 1'b0;
      #1 check("full_regrant", req_ready_o, 5'b10000);
      step();

      // Routing: grants to 3 then 0, beats come back in that order.
      do_reset(1);
      ar_ready_i  = 1'b1;
      rsp_ready_i = '1;
      req_valid_i = 5'b01000;
      #1 check("route_grant3", req_ready_o, 5'b01000);
      step();
      req_valid_i = 5'b00001;
      #1 check("route_grant0", req_ready_o, 5'b00001);
      step();
      req_valid_i = '0;
      r_valid_i   = 1'b1;
      r_data_i    = 32'h0000_AAAA;
      rsp_ready_i = 5'b10111;
      repeat (2) begin
         #1;
         check("route_hold_ready", r_ready_o, 0);
         check("route_valid3", rsp_valid_o, 5'b01000);
         step();
      end
      rsp_ready_i = '1;
      #1;
      check("route_ready3", r_ready_o, 1);
      check("route_data3", rsp_data_o, 32'h0000_AAAA);
      step();
      r_data_i = 32'h0000_BBBB;
      #1;
      check("route_valid0", rsp_valid_o, 5'b00001);
      check("route_data0", rsp_data_o, 32'h0000_BBBB);
      step();

      // Error response, then a beat with nothing outstanding.
      r_valid_i   = 1'b0;
      req_valid_i = 5'b00010;
      step();
      req_valid_i = '0;
      r_valid_i   = 1'b1;
      r_resp_i    = 2'b10;
      #1 check("err_flag", rsp_err_o, 1);
      step();
      r_resp_i = 2'b00;
      #1 check("unexp_ready", r_ready_o, 0);
      step();
      r_valid_i = 1'b0;
      #1 check("unexp_set", unexpected_rsp_o, 1);
      repeat (3) step();
      check("unexp_held", unexpected_rsp_o, 1);

      // Reset mid-operation: two reads outstanding and AR stalled.
      do_reset(1);
      req_valid_i = '1;
      ar_ready_i  = 1'b1;
      rsp_ready_i = '1;
      repeat (2) step();
      ar_ready_i = 1'b0;
      step();
      check("mid_ar_valid_before", ar_valid_o, 1);
      r_valid_i = 1'b1;
      #1 rst_i = 1'b1;
      #1;
      check("mid_ar_valid", ar_valid_o, 0);
      check("mid_ar_addr", ar_addr_o, 0);
      check("mid_req_ready", req_ready_o, 0);
      check("mid_rsp_valid", rsp_valid_o, 0);
      check("mid_r_ready", r_ready_o, 0);
      check("mid_full", outst_full_o, 0);
      check("mid_unexpected", unexpected_rsp_o, 0);
      @(posedge clk_i);
      #1;
      do_reset(2);
      req_valid_i = '1;
      ar_ready_i  = 1'b1;
      #1 check("mid_first_grant", req_ready_o, 5'b00001);
      step();

      // Random traffic against the model, with one reset in the middle.
      do_reset(1);
      for (int c = 0; c < 400; c++) begin
         if (c == 200) do_reset(2);
         req_valid_i = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 31));
         for (int i = 0; i < N; i++) req_addr_i[i*AW +: AW] = $urandom;
         ar_ready_i  = ($urandom_range(0, 3) != 0);
         r_valid_i   = (exp_q.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
         rsp_ready_i = N'($urandom_range(0, 31));
         r_resp_i    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         r_data_i    = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cgra_read_arbiter.md
CGRA_READ_ARBITER -- requirements
Module: cgra_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, number of read requesters (4 input streams plus 1 config stream).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, read address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, read data width.
REQ-004 SHALL have parameter OUTST_DEPTH, default 4, maximum number of outstanding reads; power of two, at least 2.
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester read address; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port req_valid_i  in  NUM_REQ  per-requester read request valid.
REQ-009 SHALL have port req_ready_o  out  NUM_REQ  per-requester request accepted.
REQ-010 SHALL have port rsp_data_o  out  DATA_WIDTH  response data, broadcast to all requesters.
REQ-011 SHALL have port rsp_err_o  out  1  response error; high when r_resp_i is not 2'b00.
REQ-012 SHALL have port rsp_valid_o  out  NUM_REQ  per-requester response valid.
REQ-013 SHALL have port rsp_ready_i  in  NUM_REQ  per-requester response ready.
REQ-014 SHALL have ports ar_addr_o (out, ADDR_WIDTH), ar_valid_o (out, 1) and ar_ready_i (in, 1), forming the AXI-Lite AR channel.
REQ-015 SHALL have ports r_data_i (in, DATA_WIDTH), r_resp_i (in, 2), r_valid_i (in, 1) and r_ready_o (out, 1), forming the AXI-Lite R channel.
REQ-016 SHALL have port outst_full_o  out  1  outstanding-tracking FIFO full; used as the read-stall indicator.
REQ-017 SHALL have port unexpected_rsp_o  out  1  sticky flag; set when r_valid_i is high while no read is outstanding.

Function
REQ-018 Arbitration SHALL be round-robin. Priority starts at pointer p and wraps modulo NUM_REQ. After a grant to k, p becomes (k+1) mod NUM_REQ.
REQ-019 A grant SHALL occur in a cycle only when all of the following hold:
- at least one req_valid_i is high;
- the FIFO is not full (registered count < OUTST_DEPTH);
- the AR register is empty, or is being emptied by an ar_valid_o && ar_ready_i handshake in that same cycle.
REQ-020 In a grant cycle, req_ready_o SHALL be one-hot at the winner; in all other cycles req_ready_o SHALL be all zero. The request is accepted combinationally in that cycle.
REQ-021 On a grant, the winner's address SHALL be registered into ar_addr_o, and ar_valid_o SHALL be high from the next cycle. This gives 1 cycle of latency from request acceptance to AR valid.
REQ-022 ar_addr_o SHALL remain stable while ar_valid_o is high and ar_ready_i is low. ar_valid_o SHALL fall after the handshake unless a new grant reloads the register in the same cycle.
REQ-023 On a grant, the winner index SHALL be pushed into the OUTST_DEPTH-entry in-order FIFO.
REQ-024 R routing SHALL use the FIFO head index h:
- rsp_valid_o[h] = r_valid_i && !empty, and all other bits of rsp_valid_o are 0;
- r_ready_o = rsp_ready_i[h] && !empty;
- rsp_data_o = r_data_i, passed through combinationally.
REQ-025 The FIFO SHALL pop on r_valid_i && r_ready_o.
REQ-026 When the FIFO is full, a same-cycle pop SHALL NOT enable a push; the full check uses the registered count. Push and pop may occur together when the FIFO is not full, and the count is then unchanged.
REQ-027 Read and write pointers SHALL wrap modulo OUTST_DEPTH.
REQ-028 If r_valid_i is high while the FIFO is empty:
- r_ready_o SHALL be 0;
- unexpected_rsp_o SHALL be set and held until reset.
REQ-029 The arbiter SHALL NOT reorder responses; responses are assumed to return in AR issue order.

Reset
REQ-030 While rst_i is high, and immediately on its assertion including mid-transaction, the following SHALL be cleared:
- p = 0;
- FIFO empty, with both pointers at 0;
- ar_valid_o = 0 and ar_addr_o = 0;
- unexpected_rsp_o = 0.
REQ-031 During reset, req_ready_o, rsp_valid_o and r_ready_o SHALL be 0, and outst_full_o SHALL be 0.
REQ-032 Reads in flight at reset SHALL be discarded. Their R beats after reset are handled per REQ-028.

Verification
REQ-033 Fairness: all 5 req_valid_i held high, ar_ready_i=1, R responses returned promptly -> grants in order 0,1,2,3,4,0, with one grant per cycle.
REQ-034 Backpressure: single request from requester 2 at address 0x80000010, ar_ready_i=0 for 3 cycles -> ar_addr_o=0x80000010 is stable with ar_valid_o high for 4 cycles, and req_ready_o=0 for all requesters meanwhile.
REQ-035 Full: r_valid_i=0, 4 grants issued -> outst_full_o=1 and no 5th grant. In the first cycle of an R handshake, still no grant (REQ-026); the grant occurs on the following cycle.
REQ-036 Routing: grants to 3 then 0, R beats 0xAAAA then 0xBBBB -> rsp_valid_o[3] sees 0xAAAA, then rsp_valid_o[0] sees 0xBBBB. With rsp_ready_i[3]=0, r_ready_o stays 0 until it rises.
REQ-037 Error and unexpected: r_resp_i=2'b10 on a beat -> rsp_err_o=1 that cycle. r_valid_i asserted with the FIFO empty -> r_ready_o=0 and unexpected_rsp_o=1 held.
REQ-038 Mid-operation reset: rst_i pulsed with 2 reads outstanding and ar_valid_o high -> all outputs zero immediately, and the first grant after reset goes to requester 0.
